// File: rtl/alu_wb_stage.sv
// ALU writeback stage: condition evaluation, NZCV update and a small
// result FIFO feeding a stallable register-file write port.
module alu_wb_stage #(
  parameter int RD_W  = 4,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_res,
  input  logic [3:0]      in_flags,
  input  logic            in_setf,
  input  logic [3:0]      in_cond,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_res,
  output logic [RD_W-1:0] out_rd,
  output logic            out_we,
  output logic [3:0]      nzcv
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [31:0]     r_res [DEPTH];
  logic [RD_W-1:0] r_rd  [DEPTH];
  logic            r_we  [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_cnt;
  logic [3:0]      r_nzcv;

  logic w_push;
  logic w_pop;
  logic w_pass;

  function automatic logic f_cond(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic n, z, cf, v, p;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    p  = 1'b0;
    unique case (c)
      4'h0: p = z;
      4'h1: p = ~z;
      4'h2: p = cf;
      4'h3: p = ~cf;
      4'h4: p = n;
      4'h5: p = ~n;
      4'h6: p = v;
      4'h7: p = ~v;
      4'h8: p = cf & ~z;
      4'h9: p = ~cf | z;
      4'hA: p = (n == v);
      4'hB: p = (n != v);
      4'hC: p = ~z & (n == v);
      4'hD: p = z | (n != v);
      4'hE: p = 1'b1;
      4'hF: p = 1'b0;
    endcase
    return p;
  endfunction

  // Handshakes depend only on registered occupancy
  always_comb begin
    in_ready  = (r_cnt != CNT_FULL);
    out_valid = (r_cnt != '0);
    w_push    = in_valid & in_ready;
    w_pop     = out_valid & out_ready;
    w_pass    = f_cond(in_cond, r_nzcv);
  end

  assign out_res = r_res[r_rptr];
  assign out_rd  = r_rd[r_rptr];
  assign out_we  = r_we[r_rptr];
  assign nzcv    = r_nzcv;

  // FIFO storage, pointers, occupancy and architectural flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_res[i] <= '0;
        r_rd[i]  <= '0;
        r_we[i]  <= 1'b0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_nzcv <= 4'b0000;
    end else begin
      if (w_push) begin
        r_res[r_wptr] <= in_res;
        r_rd[r_wptr]  <= in_rd;
        r_we[r_wptr]  <= w_pass;
        r_wptr        <= r_wptr + 1'b1;
        if (w_pass & in_setf)
          r_nzcv <= in_flags;
      end
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push & ~w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop & ~w_push)
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: directed scenarios plus
// randomized traffic against a table-level reference model.
module tb_alu_wb_stage;

  localparam int RD_W  = 4;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_res;
  logic [3:0]      in_flags;
  logic            in_setf;
  logic [3:0]      in_cond;
  logic [RD_W-1:0] in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_res;
  logic [RD_W-1:0] out_rd;
  logic            out_we;
  logic [3:0]      nzcv;

  always #5 clk = ~clk;

  alu_wb_stage #(.RD_W(RD_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .in_flags(in_flags),
    .in_setf(in_setf), .in_cond(in_cond),
    .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_rd(out_rd),
    .out_we(out_we), .nzcv(nzcv)
  );

  typedef struct {
    logic [31:0]     res;
    logic [RD_W-1:0] rd;
    logic            we;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [3:0] m_nzcv;
  int         n_chk  = 0;
  int         n_fail = 0;
  bit         chk_en = 1'b0;
  int         st;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference condition: ARM pairs share a base test, odd code inverts
  function automatic bit ref_pass(input logic [3:0] f,
                                  input logic [3:0] c);
    bit n, z, cf, v, base;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // Monitor: occupancy/flag checks and scoreboard pops
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("nzcv", 32'(nzcv), 32'(m_nzcv));
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_pop: got res %0h expected none",
                   out_res);
        end else begin
          mon_e = q.pop_front();
          check("out_res", out_res, mon_e.res);
          check("out_rd", 32'(out_rd), 32'(mon_e.rd));
          check("out_we", 32'(out_we), 32'(mon_e.we));
        end
      end
    end
  end

  // Accept recorder: models condition/NZCV and queues expectations
  always begin
    bit p;
    @(negedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_nzcv = 4'b0000;
    end else if (in_valid && in_ready) begin
      p = ref_pass(m_nzcv, in_cond);
      q.push_back('{in_res, in_rd, p});
      if (p && in_setf)
        m_nzcv = in_flags;
    end
  end

  task automatic send(input logic [31:0] r,
                      input logic [3:0] f,
                      input logic s,
                      input logic [3:0] c,
                      input logic [RD_W-1:0] d,
                      output int stalls);
    bit acc;
    in_res   = r;
    in_flags = f;
    in_setf  = s;
    in_cond  = c;
    in_rd    = d;
    in_valid = 1'b1;
    stalls   = 0;
    acc      = 1'b0;
    while (!acc && stalls < 50) begin
      @(negedge clk);
      if (in_ready === 1'b1) acc = 1'b1;
      else stalls++;
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_res    = '0;
    in_flags  = '0;
    in_setf   = 1'b0;
    in_cond   = '0;
    in_rd     = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_res", out_res, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_out_we", 32'(out_we), 32'd0);
    check("rst_nzcv", 32'(nzcv), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: single op, one-cycle latency
    send(32'd5, 4'b0000, 1'b1, 4'hE, 4'd3, st);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_res", out_res, 32'd5);
    check("t1_rd", 32'(out_rd), 32'd3);
    check("t1_we", 32'(out_we), 32'd1);
    check("t1_nzcv", 32'(nzcv), 32'd0);

    // 2: back-to-back flag forwarding, EQ then NE
    send(32'd6, 4'b0100, 1'b1, 4'hE, 4'd1, st);
    send(32'd7, 4'b0000, 1'b0, 4'h0, 4'd2, st);
    check("t2_eq_rd", 32'(out_rd), 32'd2);
    check("t2_eq_we", 32'(out_we), 32'd1);
    send(32'd8, 4'b0000, 1'b0, 4'h1, 4'd4, st);
    check("t2_ne_we", 32'(out_we), 32'd0);
    check("t2_nzcv", 32'(nzcv), 32'h4);

    // 3: failed op with setf leaves flags alone
    send(32'd0, 4'b0000, 1'b1, 4'hE, 4'd0, st);
    send(32'd9, 4'b1000, 1'b1, 4'h0, 4'd5, st);
    check("t3_we", 32'(out_we), 32'd0);
    check("t3_nzcv", 32'(nzcv), 32'd0);
    idle(2);

    // 4: backpressure, full blocks push despite same-cycle pop
    out_ready = 1'b0;
    send(32'd101, 4'b0000, 1'b0, 4'hE, 4'd1, st);
    send(32'd102, 4'b0000, 1'b0, 4'hE, 4'd2, st);
    check("t4_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(32'd103, 4'b0000, 1'b0, 4'hE, 4'd3, st);
    check("t4_stalls", 32'(st), 32'd1);
    idle(4);

    // 5: every flag value against every condition
    for (int nz = 0; nz < 16; nz++) begin
      for (int c = 0; c < 16; c++) begin
        send($urandom, 4'(nz), 1'b1, 4'hE, RD_W'(c), st);
        send($urandom, 4'($urandom), 1'b0, 4'(c), RD_W'(nz), st);
      end
    end
    idle(4);

    // 6: reset discards buffered entries
    out_ready = 1'b0;
    send(32'd201, 4'b1111, 1'b1, 4'hE, 4'd1, st);
    send(32'd202, 4'b0000, 1'b0, 4'hE, 4'd2, st);
    check("t6_pre_nzcv", 32'(nzcv), 32'hF);
    check("t6_pre_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_nzcv", 32'(nzcv), 32'd0);
    check("t6_ready", 32'(in_ready), 32'd1);
    check("t6_res", out_res, 32'd0);
    out_ready = 1'b1;
    idle(5);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_res    = $urandom;
      in_flags  = 4'($urandom);
      in_setf   = 1'($urandom);
      in_cond   = 4'($urandom);
      in_rd     = RD_W'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(8);
    check("drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
